// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner.
//   DefaultDebounceCycles : default for DEBOUNCE_CYCLES
//   ch_state_e            : per-channel debounce state, 2-bit encoding
package input_conditioner_pkg;

  localparam int unsigned DefaultDebounceCycles = 4;

  // Bit 1 is the debounced output level in every state, so the channel can
  // drive its output straight from the state register.
  typedef enum logic [1:0] {
    StStableLo = 2'b00,
    StPendHi   = 2'b01,
    StStableHi = 2'b10,
    StPendLo   = 2'b11
  } ch_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input channel: 2-flop synchronizer, mismatch counter,
// 4-state debounce FSM and a one-cycle change pulse.
//   clk_i   : system clock, rising edge
//   rst_i   : asynchronous active-high reset
//   raw_i   : raw asynchronous contact
//   level_o : debounced level (registered)
//   edge_o  : one-cycle pulse in the cycle after level_o changes (registered)
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic edge_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  ch_state_e       state_q, state_d;
  logic            edge_q, edge_d;
  logic            synced;
  logic            terminal;

  assign synced   = sync_q[1];
  assign terminal = (cnt_q == CntLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      state_q <= StStableLo;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      state_q <= state_d;
      edge_q  <= edge_d;
    end
  end

  // Count is zero in both stable states, so the first mismatch edge counts 1.
  // Any edge where the synced value agrees again drops the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    edge_d  = 1'b0;
    unique case (state_q)
      StStableLo: begin
        if (synced) begin
          state_d = StPendHi;
          cnt_d   = CntOne;
        end
      end
      StPendHi: begin
        if (!synced) begin
          state_d = StStableLo;
        end else if (terminal) begin
          state_d = StStableHi;
          edge_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStableHi: begin
        if (!synced) begin
          state_d = StPendLo;
          cnt_d   = CntOne;
        end
      end
      StPendLo: begin
        if (synced) begin
          state_d = StStableHi;
        end else if (terminal) begin
          state_d = StStableLo;
          edge_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StStableLo;
    endcase
  end

  assign level_o = state_q[1];
  assign edge_o  = edge_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces the S and I contacts for the downstream controller.
//   Clock  : system clock, rising edge
//   R      : asynchronous active-high reset
//   S_raw  : raw sensor contact      -> S, S_edge
//   I_raw  : raw enable contact      -> I, I_edge
//   S, I   : debounced registered levels
//   S_edge, I_edge : one-cycle pulse after the matching level changes
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
  input  logic Clock,
  input  logic R,
  input  logic S_raw,
  input  logic I_raw,
  output logic S,
  output logic I,
  output logic S_edge,
  output logic I_edge
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_s_chan (
    .clk_i  (Clock),
    .rst_i  (R),
    .raw_i  (S_raw),
    .level_o(S),
    .edge_o (S_edge)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_i_chan (
    .clk_i  (Clock),
    .rst_i  (R),
    .raw_i  (I_raw),
    .level_o(I),
    .edge_o (I_edge)
  );

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with an edge-pulse scoreboard.
module tb_input_conditioner;

  logic Clock;
  logic R;
  logic S_raw;
  logic I_raw;
  logic S;
  logic I;
  logic S_edge;
  logic I_edge;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  bit done   = 1'b0;

  typedef struct {
    int   at;
    logic lvl;
  } ev_t;

  ev_t sq[$];
  ev_t iq[$];

  input_conditioner #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .Clock (Clock),
    .R     (R),
    .S_raw (S_raw),
    .I_raw (I_raw),
    .S     (S),
    .I     (I),
    .S_edge(S_edge),
    .I_edge(I_edge)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Rising-edge index; stable when sampled at the falling edge.
  initial forever begin
    @(posedge Clock);
    edge_n++;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic push_s(input int at, input logic lvl);
    ev_t e;
    e.at  = at;
    e.lvl = lvl;
    sq.push_back(e);
  endtask

  task automatic push_i(input int at, input logic lvl);
    ev_t e;
    e.at  = at;
    e.lvl = lvl;
    iq.push_back(e);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Monitor: every observed pulse must match the head of its queue in both
  // timing and resulting level; an overdue head counts as a missed pulse.
  initial begin
    logic s_prev;
    logic i_prev;
    ev_t  e;
    s_prev = 1'b0;
    i_prev = 1'b0;
    while (!done) begin
      @(negedge Clock);
      if (!R) begin
        if (S_edge) begin
          checks++;
          if (sq.size() == 0) begin
            errors++;
            $display("FAIL s_edge_unexpected: pulse at edge %0d, none expected", edge_n);
          end else begin
            e = sq.pop_front();
            if (e.at != edge_n || S !== e.lvl) begin
              errors++;
              $display("FAIL s_edge: edge %0d level %b, expected edge %0d level %b",
                       edge_n, S, e.at, e.lvl);
            end
          end
          if (s_prev) begin
            errors++;
            $display("FAIL s_edge_double: consecutive pulses at edge %0d", edge_n);
          end
        end
        if (I_edge) begin
          checks++;
          if (iq.size() == 0) begin
            errors++;
            $display("FAIL i_edge_unexpected: pulse at edge %0d, none expected", edge_n);
          end else begin
            e = iq.pop_front();
            if (e.at != edge_n || I !== e.lvl) begin
              errors++;
              $display("FAIL i_edge: edge %0d level %b, expected edge %0d level %b",
                       edge_n, I, e.at, e.lvl);
            end
          end
          if (i_prev) begin
            errors++;
            $display("FAIL i_edge_double: consecutive pulses at edge %0d", edge_n);
          end
        end
        if (sq.size() > 0 && sq[0].at < edge_n) begin
          checks++;
          errors++;
          $display("FAIL s_edge_missing: got none, expected pulse at edge %0d", sq[0].at);
          void'(sq.pop_front());
        end
        if (iq.size() > 0 && iq[0].at < edge_n) begin
          checks++;
          errors++;
          $display("FAIL i_edge_missing: got none, expected pulse at edge %0d", iq[0].at);
          void'(iq.pop_front());
        end
      end
      s_prev = S_edge;
      i_prev = I_edge;
    end
  end

  // Inputs change at falling edges, so the next rising edge is edge_n+1 and
  // a debounced change (4 cycles) is seen as a pulse at edge_n+6.
  initial begin
    R     = 1'b1;
    S_raw = 1'b0;
    I_raw = 1'b0;
    #3;
    chk("reset_s", S, 1'b0);
    chk("reset_i", I, 1'b0);
    chk("reset_s_edge", S_edge, 1'b0);
    chk("reset_i_edge", I_edge, 1'b0);
    ticks(2);
    R = 1'b0;
    ticks(2);

    // Clean rise on S.
    S_raw = 1'b1;
    push_s(edge_n + 6, 1'b1);
    ticks(10);

    // Three-cycle glitch on I is discarded.
    I_raw = 1'b1;
    ticks(3);
    I_raw = 1'b0;
    ticks(10);
    chk("i_glitch_level", I, 1'b0);

    // Clean fall on S.
    S_raw = 1'b0;
    push_s(edge_n + 6, 1'b0);
    ticks(10);

    // Bounce 1,0,1,0 then hold 1: timed from the final rising drive.
    S_raw = 1'b1;
    ticks(1);
    S_raw = 1'b0;
    ticks(1);
    S_raw = 1'b1;
    ticks(1);
    S_raw = 1'b0;
    ticks(1);
    S_raw = 1'b1;
    push_s(edge_n + 6, 1'b1);
    ticks(12);

    // Fall again, then both channels rise together.
    S_raw = 1'b0;
    push_s(edge_n + 6, 1'b0);
    ticks(10);
    S_raw = 1'b1;
    I_raw = 1'b1;
    push_s(edge_n + 6, 1'b1);
    push_i(edge_n + 6, 1'b1);
    ticks(10);
    chk("both_s_level", S, 1'b1);
    chk("both_i_level", I, 1'b1);

    I_raw = 1'b0;
    push_i(edge_n + 6, 1'b0);
    ticks(10);

    // Reset mid-debounce on I while S is high and S_raw stays high.
    I_raw = 1'b1;
    ticks(2);
    R = 1'b1;
    #1;
    chk("mid_reset_s", S, 1'b0);
    chk("mid_reset_i", I, 1'b0);
    chk("mid_reset_s_edge", S_edge, 1'b0);
    chk("mid_reset_i_edge", I_edge, 1'b0);
    ticks(2);
    R = 1'b0;
    push_s(edge_n + 6, 1'b1);
    push_i(edge_n + 6, 1'b1);
    ticks(4);
    chk("post_reset_s_not_yet", S, 1'b0);
    chk("post_reset_i_not_yet", I, 1'b0);
    ticks(8);

    // Falling transition from steady high.
    S_raw = 1'b0;
    push_s(edge_n + 6, 1'b0);
    ticks(10);

    // Toggling every cycle never moves the output.
    for (int k = 0; k < 20; k++) begin
      S_raw = ~S_raw;
      ticks(1);
    end
    S_raw = 1'b0;
    ticks(10);
    chk("toggle_s_level", S, 1'b0);
    chk("final_i_level", I, 1'b1);

    checks++;
    if (sq.size() != 0 || iq.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: %0d S and %0d I pulses outstanding, expected 0",
               sq.size(), iq.size());
    end

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
